seg_readback_decoder: RTL and testbench



---
 rtl/seg_readback_decoder.sv | 195 +++++++++++++++++++
 tb/tb_seg_readback_decoder.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_readback_decoder.sv
// Reconstructs the BCD digit shown on each position of a multiplexed active-low 7-segment bus.
// Optional build macro BLANK_AS_ERROR_EN: the blank pattern 7'h7F is treated as an illegal capture.
//
// state   | meaning
// --------+---------------------------------------------------------------
// SETTLE  | sample changed recently; waiting for STABLE_CYCLES identical samples
// CAPTURE | sample is stable; decode it and update the per-position registers
// HELD    | capture done; bus ignored until the sample changes
module seg_readback_decoder #(
    parameter int NUM_DIGITS    = 6,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [6:0]              seg_data,
    input  logic [NUM_DIGITS-1:0]   an,
    input  logic                    clear,
    output logic [4*NUM_DIGITS-1:0] digits_out,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    frame_done,
    output logic                    err_pattern,
    output logic                    err_anode
);

    localparam logic [1:0] SETTLE  = 2'd0;
    localparam logic [1:0] CAPTURE = 2'd1;
    localparam logic [1:0] HELD    = 2'd2;

    localparam int                  SAMPLE_W    = NUM_DIGITS + 7;
    localparam logic [SAMPLE_W-1:0] SAMPLE_IDLE = '1;
    localparam logic [7:0]          STABLE_TC   = 8'(STABLE_CYCLES);

    logic [SAMPLE_W-1:0]   sample_q;
    logic [7:0]            stable_cnt;
    logic [1:0]            state_q;
    logic [NUM_DIGITS-1:0] mask_q;
    logic [4*NUM_DIGITS-1:0] digits_q;
    logic [NUM_DIGITS-1:0] valid_q;
    logic                  frame_done_q;
    logic                  err_pattern_q;
    logic                  err_anode_q;

    logic [SAMPLE_W-1:0]   sample_in;
    logic                  sample_diff;
    logic [7:0]            cnt_next;

    logic [1:0]            state_d;
    logic [7:0]            cnt_d;
    logic [NUM_DIGITS-1:0] mask_d;
    logic [4*NUM_DIGITS-1:0] digits_d;
    logic [NUM_DIGITS-1:0] valid_d;
    logic                  frame_done_d;
    logic                  err_pattern_d;
    logic                  err_anode_d;

    logic [NUM_DIGITS-1:0] cap_sel;
    logic [6:0]            cap_seg;
    logic                  cap_any;
    logic                  cap_one;
    logic                  cap_multi;
    logic [4:0]            cap_decode;
    logic                  cap_legal;
    logic [3:0]            cap_bcd;

    // Returns {legal, bcd}; illegal patterns return bcd = 4'hF, which is never written.
    function automatic logic [4:0] decode_seg(input logic [6:0] seg);
        logic [4:0] res;
        case (seg)
            7'h01:   res = 5'b1_0000;
            7'h4F:   res = 5'b1_0001;
            7'h12:   res = 5'b1_0010;
            7'h06:   res = 5'b1_0011;
            7'h4C:   res = 5'b1_0100;
            7'h24:   res = 5'b1_0101;
            7'h20:   res = 5'b1_0110;
            7'h0F:   res = 5'b1_0111;
            7'h00:   res = 5'b1_1000;
            7'h0C:   res = 5'b1_1001;
`ifdef BLANK_AS_ERROR_EN
            7'h7F:   res = 5'b0_1111;
`else
            7'h7F:   res = 5'b1_1111;
`endif
            default: res = 5'b0_1111;
        endcase
        return res;
    endfunction

    assign sample_in   = {an, seg_data};
    assign sample_diff = (sample_in != sample_q);

    always_comb begin
        if (sample_diff) begin
            cnt_next = 8'd1;
        end else if (stable_cnt == STABLE_TC) begin
            cnt_next = STABLE_TC;
        end else begin
            cnt_next = stable_cnt + 8'd1;
        end
    end

    // Capture always works on the registered sample, i.e. the pattern that was counted stable.
    assign cap_sel    = ~sample_q[SAMPLE_W-1:7];
    assign cap_seg    = sample_q[6:0];
    assign cap_any    = |cap_sel;
    assign cap_one    = $onehot(cap_sel);
    assign cap_multi  = cap_any & ~cap_one;
    assign cap_decode = decode_seg(cap_seg);
    assign cap_legal  = cap_decode[4];
    assign cap_bcd    = cap_decode[3:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            SETTLE:  if (cnt_next == STABLE_TC) state_d = CAPTURE;
            CAPTURE: state_d = sample_diff ? SETTLE : HELD;
            HELD:    if (sample_diff) state_d = SETTLE;
            default: state_d = SETTLE;
        endcase
    end

    always_comb begin
        cnt_d         = cnt_next;
        mask_d        = mask_q;
        digits_d      = digits_q;
        valid_d       = valid_q;
        frame_done_d  = 1'b0;
        err_pattern_d = 1'b0;
        err_anode_d   = 1'b0;

        // A full mask is retired first so a coincident capture lands in the fresh frame.
        if (&mask_q) begin
            frame_done_d = 1'b1;
            mask_d       = '0;
        end

        if (state_q == CAPTURE) begin
            if (cap_multi) begin
                err_anode_d = 1'b1;
            end else if (cap_one) begin
                mask_d        = mask_d | cap_sel;
                err_pattern_d = ~cap_legal;
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (cap_sel[i]) begin
                        valid_d[i] = cap_legal;
                        if (cap_legal) begin
                            digits_d[4*i +: 4] = cap_bcd;
                        end
                    end
                end
            end
        end

        if (clear) begin
            cnt_d         = 8'd0;
            mask_d        = '0;
            digits_d      = '1;
            valid_d       = '0;
            frame_done_d  = 1'b0;
            err_pattern_d = 1'b0;
            err_anode_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q      <= SAMPLE_IDLE;
            stable_cnt    <= 8'd0;
            state_q       <= SETTLE;
            mask_q        <= '0;
            digits_q      <= '1;
            valid_q       <= '0;
            frame_done_q  <= 1'b0;
            err_pattern_q <= 1'b0;
            err_anode_q   <= 1'b0;
        end else begin
            sample_q      <= sample_in;
            stable_cnt    <= cnt_d;
            state_q       <= clear ? SETTLE : state_d;
            mask_q        <= mask_d;
            digits_q      <= digits_d;
            valid_q       <= valid_d;
            frame_done_q  <= frame_done_d;
            err_pattern_q <= err_pattern_d;
            err_anode_q   <= err_anode_d;
        end
    end

    assign digits_out  = digits_q;
    assign digit_valid = valid_q;
    assign frame_done  = frame_done_q;
    assign err_pattern = err_pattern_q;
    assign err_anode   = err_anode_q;

endmodule

// File: tb/tb_seg_readback_decoder.sv
// Self-checking bench for seg_readback_decoder: directed tables, corner sequences and a
// randomized run against a run-length based reference model.
module tb_seg_readback_decoder;

    localparam int ND = 6;
    localparam int SC = 4;
`ifdef BLANK_AS_ERROR_EN
    localparam bit BLANK_ERR = 1'b1;
`else
    localparam bit BLANK_ERR = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [6:0]      seg_data = 7'h7F;
    logic [ND-1:0]   an = '1;
    logic            clear = 1'b0;
    logic [4*ND-1:0] digits_out;
    logic [ND-1:0]   digit_valid;
    logic            frame_done;
    logic            err_pattern;
    logic            err_anode;

    always #5 clk = ~clk;

    seg_readback_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
        .clk(clk), .rst_n(rst_n), .seg_data(seg_data), .an(an), .clear(clear),
        .digits_out(digits_out), .digit_valid(digit_valid), .frame_done(frame_done),
        .err_pattern(err_pattern), .err_anode(err_anode)
    );

    int total = 0;
    int bad = 0;
    int fd_cnt, ep_cnt, ea_cnt;

    // Reference model state
    logic [6:0]    legal_tab [10];
    logic [3:0]    m_dig [ND];
    logic [ND-1:0] m_val, m_mask;
    logic          m_fd, m_ep, m_ea;
    logic [ND+6:0] m_prev;
    int            m_run;
    bit            m_pend;

    typedef struct {
        logic [ND-1:0]   an;
        logic [6:0]      seg;
        logic [4*ND-1:0] exp_dig;
        logic [ND-1:0]   exp_val;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ND; i++) m_dig[i] = 4'hF;
        m_val  = '0;
        m_mask = '0;
        m_fd   = 1'b0;
        m_ep   = 1'b0;
        m_ea   = 1'b0;
        m_prev = '1;
        m_run  = 0;
        m_pend = 1'b0;
    endfunction

    // A pattern is captured one edge after it has been seen SC times in a row, unless clear intervenes.
    function automatic void model_edge(input logic [ND-1:0] a, input logic [6:0] s, input logic c);
        logic [ND-1:0] sel;
        logic [6:0]    cs;
        int            nsel, pos, val;
        m_fd = 1'b0;
        m_ep = 1'b0;
        m_ea = 1'b0;
        if (c) begin
            for (int i = 0; i < ND; i++) m_dig[i] = 4'hF;
            m_val  = '0;
            m_mask = '0;
        end else begin
            if (m_mask == '1) begin
                m_fd   = 1'b1;
                m_mask = '0;
            end
            if (m_pend) begin
                sel  = ~m_prev[ND+6:7];
                cs   = m_prev[6:0];
                nsel = $countones(sel);
                if (nsel > 1) begin
                    m_ea = 1'b1;
                end else if (nsel == 1) begin
                    pos = 0;
                    for (int i = 0; i < ND; i++) if (sel[i]) pos = i;
                    val = -1;
                    for (int d = 0; d < 10; d++) if (legal_tab[d] == cs) val = d;
                    if (val < 0 && cs == 7'h7F && !BLANK_ERR) val = 15;
                    m_mask[pos] = 1'b1;
                    if (val >= 0) begin
                        m_dig[pos] = 4'(val);
                        m_val[pos] = 1'b1;
                    end else begin
                        m_val[pos] = 1'b0;
                        m_ep = 1'b1;
                    end
                end
            end
        end
        if (c) m_run = 0;
        else if ({a, s} != m_prev) m_run = 1;
        else m_run++;
        m_prev = {a, s};
        m_pend = (m_run == SC);
    endfunction

    function automatic logic [4*ND-1:0] model_digits();
        logic [4*ND-1:0] r;
        for (int i = 0; i < ND; i++) r[4*i +: 4] = m_dig[i];
        return r;
    endfunction

    task automatic check_model();
        chk("model_digits", 32'(digits_out), 32'(model_digits()));
        chk("model_valid", 32'(digit_valid), 32'(m_val));
        chk("model_frame_done", 32'(frame_done), 32'(m_fd));
        chk("model_err_pattern", 32'(err_pattern), 32'(m_ep));
        chk("model_err_anode", 32'(err_anode), 32'(m_ea));
    endtask

    task automatic step(input logic [ND-1:0] a, input logic [6:0] s, input logic c);
        an       = a;
        seg_data = s;
        clear    = c;
        @(posedge clk);
        model_edge(a, s, c);
        #1;
        check_model();
        fd_cnt += int'(frame_done);
        ep_cnt += int'(err_pattern);
        ea_cnt += int'(err_anode);
    endtask

    task automatic hold(input logic [ND-1:0] a, input logic [6:0] s, input int n);
        for (int k = 0; k < n; k++) step(a, s, 1'b0);
    endtask

    task automatic zero_counts();
        fd_cnt = 0;
        ep_cnt = 0;
        ea_cnt = 0;
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, "_digits"}, 32'(digits_out), 32'h00FF_FFFF);
        chk({tag, "_valid"}, 32'(digit_valid), 32'h0);
        chk({tag, "_pulses"}, {29'd0, frame_done, err_pattern, err_anode}, 32'h0);
    endtask

    initial begin
        logic [ND-1:0] ra;
        logic [6:0]    rs;
        int            r, p, q, len;

        legal_tab = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F, 7'h00, 7'h0C};
        vecs[0] = '{6'b111110, 7'h4F, 24'hFFFFF1, 6'b000001};
        vecs[1] = '{6'b111101, 7'h12, 24'hFFFF21, 6'b000011};
        vecs[2] = '{6'b111011, 7'h24, 24'hFFF521, 6'b000111};
        vecs[3] = '{6'b110111, 7'h0C, 24'hFF9521, 6'b001111};
        vecs[4] = '{6'b101111, 7'h06, 24'hF39521, 6'b011111};
        vecs[5] = '{6'b011111, 7'h01, 24'h039521, 6'b111111};
        model_reset();
        zero_counts();

        #23;
        check_reset_values("in_reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle blanking after reset
        hold('1, 7'h7F, 20);
        check_reset_values("idle");

        // Capture latency: first sample edge plus SC edges
        for (int k = 0; k < SC; k++) step(6'b111110, 7'h12, 1'b0);
        chk("latency_before", 32'(digit_valid[0]), 32'h0);
        step(6'b111110, 7'h12, 1'b0);
        chk("latency_valid", 32'(digit_valid[0]), 32'h1);
        chk("latency_digit", 32'(digits_out[3:0]), 32'h2);
        hold(6'b111110, 7'h12, 4);
        hold('1, 7'h7F, 2);

        // Full scan from a cleared state
        step('1, 7'h7F, 1'b1);
        hold('1, 7'h7F, 2);
        zero_counts();
        for (int v = 0; v < 6; v++) begin
            hold(vecs[v].an, vecs[v].seg, 6);
            hold('1, 7'h7F, 2);
            chk($sformatf("scan%0d_digits", v), 32'(digits_out), 32'(vecs[v].exp_dig));
            chk($sformatf("scan%0d_valid", v), 32'(digit_valid), 32'(vecs[v].exp_val));
        end
        chk("scan_frame_done_count", 32'(fd_cnt), 32'd1);
        zero_counts();
        for (int v = 0; v < 5; v++) begin
            hold(vecs[v].an, vecs[v].seg, 6);
            hold('1, 7'h7F, 2);
        end
        chk("partial_rescan_no_frame", 32'(fd_cnt), 32'd0);

        // Glitch shorter than SC samples is ignored
        step('1, 7'h7F, 1'b1);
        hold('1, 7'h7F, 2);
        zero_counts();
        hold(6'b111101, 7'h4F, 3);
        chk("glitch_no_update", 32'(digit_valid), 32'h0);
        hold(6'b111101, 7'h24, 5);
        chk("glitch_digit", 32'(digits_out[7:4]), 32'h5);
        chk("glitch_valid", 32'(digit_valid[1]), 32'h1);
        hold('1, 7'h7F, 2);

        // Illegal pattern then multiple anodes
        hold(6'b111011, 7'h0F, 5);
        hold('1, 7'h7F, 2);
        zero_counts();
        hold(6'b111011, 7'h55, 6);
        chk("pattern_err_count", 32'(ep_cnt), 32'd1);
        chk("pattern_keep_digit", 32'(digits_out[11:8]), 32'h7);
        chk("pattern_valid", 32'(digit_valid), 32'(6'b000010));
        hold('1, 7'h7F, 2);
        zero_counts();
        hold(6'b111100, 7'h00, 6);
        chk("anode_err_count", 32'(ea_cnt), 32'd1);
        chk("anode_digits", 32'(digits_out), 32'hFFF75F);
        chk("anode_no_pattern_err", 32'(ep_cnt), 32'd0);
        hold('1, 7'h7F, 2);

        // Clear on the capture edge wins
        zero_counts();
        hold(6'b111110, 7'h06, SC);
        step(6'b111110, 7'h06, 1'b1);
        check_reset_values("clear_capture");
        hold(6'b111110, 7'h06, 2);
        hold(6'b111101, 7'h4F, 2);

        // Asynchronous reset mid-settle
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        an       = '1;
        seg_data = 7'h7F;
        clear    = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        zero_counts();
        hold('1, 7'h7F, 6);
        chk("after_reset_pulses", 32'(fd_cnt + ep_cnt + ea_cnt), 32'd0);

        // Randomized patterns against the model
        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 9);
            if (r <= 6) begin
                ra = '1;
                ra[$urandom_range(0, ND-1)] = 1'b0;
            end else if (r == 7) begin
                ra = '1;
            end else if (r == 8) begin
                ra = '1;
                p = $urandom_range(0, ND-1);
                q = (p + $urandom_range(1, ND-1)) % ND;
                ra[p] = 1'b0;
                ra[q] = 1'b0;
            end else begin
                ra = ND'($urandom);
            end
            r = $urandom_range(0, 9);
            if (r <= 7) rs = legal_tab[$urandom_range(0, 9)];
            else if (r == 8) rs = 7'h7F;
            else rs = 7'($urandom);
            len = $urandom_range(1, 8);
            for (int k = 0; k < len; k++) step(ra, rs, ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
